// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU data port and the UART loader onto one synchronous-read data RAM.
// One access every two cycles: issue in IDLE, ack with read data in BUSY.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RR_EN        = 0,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e     state;
    logic       owner;
    logic       we_q;
    logic       last_winner;
    logic [7:0] starve_cnt;

    logic       any_req;
    logic       ld_wins;
    logic       issue;
    logic       busy;
    logic [7:0] starve_next;

    always_comb begin
        any_req = cpu_req | ld_req;
        if (RR_EN != 0) begin
            ld_wins = ld_req & (~cpu_req | ~last_winner);
        end else begin
            ld_wins = ld_req & (~cpu_req | (starve_cnt == StarveMax));
        end
        // Outputs are forced low while reset is held, even with requests pending.
        issue = rst & (state == StIdle) & any_req;
        busy  = (state == StBusy);
    end

    always_comb begin
        starve_next = 8'd0;
        if ((RR_EN == 0) && ld_req && !ld_wins) begin
            starve_next = (starve_cnt == StarveMax) ? starve_cnt : starve_cnt + 8'd1;
        end
    end

    always_comb begin
        mem_en    = issue;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_we    = ld_wins ? ld_we    : cpu_we;
            mem_addr  = ld_wins ? ld_addr  : cpu_addr;
            mem_wdata = ld_wins ? ld_wdata : cpu_wdata;
        end
    end

    always_comb begin
        cpu_ack   = busy & ~owner;
        ld_ack    = busy & owner;
        cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : '0;
        ld_rdata  = (ld_ack && !we_q) ? mem_rdata : '0;
        cpu_stall = rst & cpu_req & ~cpu_ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            last_winner <= 1'b1;
            starve_cnt  <= 8'd0;
        end else begin
            case (state)
                StIdle: begin
                    starve_cnt <= starve_next;
                    if (any_req) begin
                        state       <= StBusy;
                        owner       <= ld_wins;
                        we_q        <= ld_wins ? ld_we : cpu_we;
                        last_winner <= ld_wins;
                    end
                end
                StBusy:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
